// File: rtl/d_e_pipe_reg_pkg.sv
// rtl/d_e_pipe_reg_pkg.sv - shared constants and types for the D/E pipeline register
//
// Purpose: ALU opcode values, the default bubble opcode, operand-select
// encodings and the registered D/E bundle layout used by d_e_pipe_reg.
// Ports: none (package).

package d_e_pipe_reg_pkg;

  // ALU opcodes shared with the decoder and the execute-stage ALU.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  // Opcode loaded by reset and by a bubble; an add of zeros is harmless.
  localparam logic [3:0] NOP_OP_DEFAULT = ALU_ADD;

  // A operand source.
  typedef enum logic {
    A_SEL_RS = 1'b0,
    A_SEL_RT = 1'b1
  } a_sel_t;

  // B operand source.
  typedef enum logic [1:0] {
    B_SEL_RT    = 2'd0,
    B_SEL_IMM   = 2'd1,
    B_SEL_SHAMT = 2'd2,
    B_SEL_RS    = 2'd3
  } b_sel_t;

  // Everything latched at the D/E boundary.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    a_sel_t      a_sel;
    b_sel_t      b_sel;
    logic [4:0]  dst;
    logic        reg_we;
  } de_bundle_t;

  // Shift amount field of an R-type instruction, zero-extended to a word.
  function automatic logic [31:0] shamt_ext(input logic [31:0] instr);
    return {27'b0, instr[10:6]};
  endfunction

endpackage

// File: rtl/d_e_pipe_reg_fwd_mux.sv
// rtl/d_e_pipe_reg_fwd_mux.sv - M/W operand forwarding mux for one source register
//
// Purpose: returns the newest value of a source register: the M-stage result
// if it targets this register, else the W-stage result, else the register
// data captured at decode. Register 0 never forwards.
// Ports:
//   reg_num   in  5   source register number (registered in E)
//   reg_data  in  32  register data captured in E
//   m_addr/m_data/m_we  in  M-stage destination, value, forward enable
//   w_addr/w_data/w_we  in  W-stage destination, value, forward enable
//   fwd_data  out 32  forwarded operand value

module fwd_mux (
  input  logic [4:0]  reg_num,
  input  logic [31:0] reg_data,
  input  logic [4:0]  m_addr,
  input  logic [31:0] m_data,
  input  logic        m_we,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data,
  input  logic        w_we,
  output logic [31:0] fwd_data
);

  logic reg_nonzero;
  logic m_hit;
  logic w_hit;

  assign reg_nonzero = (reg_num != 5'd0);
  assign m_hit       = m_we && (m_addr == reg_num) && reg_nonzero;
  assign w_hit       = w_we && (w_addr == reg_num) && reg_nonzero;

  // M is younger than W, so it wins when both target the same register.
  always_comb begin
    fwd_data = reg_data;
    if (m_hit) begin
      fwd_data = m_data;
    end else if (w_hit) begin
      fwd_data = w_data;
    end
  end

endmodule

// File: rtl/d_e_pipe_reg.sv
// rtl/d_e_pipe_reg.sv - decode-to-execute pipeline register with hold, bubble and forwarding
//
// Purpose: latches the decoded instruction bundle at the D/E boundary,
// applies hold/bubble control, forwards M/W results onto rs/rt and presents
// the selected ALU operands, opcode and store data to the execute stage.
// Ports:
//   clk, reset               in   clock, asynchronous active-high reset
//   hold, bubble             in   keep E contents / load a NOP into E
//   d_valid, d_pc, d_instr   in   D-stage instruction identity
//   d_rs, d_rt               in   source register numbers
//   d_rs_data, d_rt_data     in   GRF read data
//   d_imm                    in   extended immediate
//   d_alu_op, d_a_sel, d_b_sel in ALU opcode and operand selects
//   d_dst, d_reg_we          in   destination register and write enable
//   m_fwd_*, w_fwd_*         in   M/W results available for forwarding
//   e_valid, e_reg_we, e_pc, e_instr, e_dst   out  registered E fields
//   e_alu_a, e_alu_b, e_alu_op                out  ALU inputs after forwarding
//   e_store_data                              out  forwarded rt

module d_e_pipe_reg
  import d_e_pipe_reg_pkg::*;
#(
  parameter logic [3:0] NOP_OP = NOP_OP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        bubble,
  input  logic        d_valid,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_instr,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [31:0] d_rs_data,
  input  logic [31:0] d_rt_data,
  input  logic [31:0] d_imm,
  input  logic [3:0]  d_alu_op,
  input  logic        d_a_sel,
  input  logic [1:0]  d_b_sel,
  input  logic [4:0]  d_dst,
  input  logic        d_reg_we,
  input  logic [4:0]  m_fwd_addr,
  input  logic [4:0]  w_fwd_addr,
  input  logic [31:0] m_fwd_data,
  input  logic [31:0] w_fwd_data,
  input  logic        m_fwd_we,
  input  logic        w_fwd_we,
  output logic        e_valid,
  output logic        e_reg_we,
  output logic [31:0] e_pc,
  output logic [31:0] e_instr,
  output logic [31:0] e_alu_a,
  output logic [31:0] e_alu_b,
  output logic [3:0]  e_alu_op,
  output logic [31:0] e_store_data,
  output logic [4:0]  e_dst
);

  de_bundle_t q;
  de_bundle_t load_val;
  de_bundle_t bubble_val;
  de_bundle_t reset_val;

  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  // Fresh bundle straight from decode.
  always_comb begin
    load_val         = '0;
    load_val.valid   = d_valid;
    load_val.pc      = d_pc;
    load_val.instr   = d_instr;
    load_val.rs      = d_rs;
    load_val.rt      = d_rt;
    load_val.rs_data = d_rs_data;
    load_val.rt_data = d_rt_data;
    load_val.imm     = d_imm;
    load_val.alu_op  = d_alu_op;
    load_val.a_sel   = a_sel_t'(d_a_sel);
    load_val.b_sel   = b_sel_t'(d_b_sel);
    load_val.dst     = d_dst;
    load_val.reg_we  = d_reg_we;
  end

  // A bubble is an inert add of zeros, but keeps the PC so exception and
  // debug logic can still tell where the slot came from.
  always_comb begin
    bubble_val        = '0;
    bubble_val.pc     = d_pc;
    bubble_val.alu_op = NOP_OP;
  end

  always_comb begin
    reset_val        = '0;
    reset_val.alu_op = NOP_OP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= reset_val;
    end else if (bubble) begin
      q <= bubble_val;
    end else if (hold) begin
      // While stalled, absorb any forwarded value so a W result that retires
      // during the stall is not lost once it leaves the forwarding window.
      q.rs_data <= fwd_rs;
      q.rt_data <= fwd_rt;
    end else begin
      q <= load_val;
    end
  end

  fwd_mux u_fwd_rs (
    .reg_num  (q.rs),
    .reg_data (q.rs_data),
    .m_addr   (m_fwd_addr),
    .m_data   (m_fwd_data),
    .m_we     (m_fwd_we),
    .w_addr   (w_fwd_addr),
    .w_data   (w_fwd_data),
    .w_we     (w_fwd_we),
    .fwd_data (fwd_rs)
  );

  fwd_mux u_fwd_rt (
    .reg_num  (q.rt),
    .reg_data (q.rt_data),
    .m_addr   (m_fwd_addr),
    .m_data   (m_fwd_data),
    .m_we     (m_fwd_we),
    .w_addr   (w_fwd_addr),
    .w_data   (w_fwd_data),
    .w_we     (w_fwd_we),
    .fwd_data (fwd_rt)
  );

  always_comb begin
    e_alu_a = (q.a_sel == A_SEL_RT) ? fwd_rt : fwd_rs;
  end

  always_comb begin
    e_alu_b = fwd_rt;
    case (q.b_sel)
      B_SEL_RT:    e_alu_b = fwd_rt;
      B_SEL_IMM:   e_alu_b = q.imm;
      B_SEL_SHAMT: e_alu_b = shamt_ext(q.instr);
      B_SEL_RS:    e_alu_b = fwd_rs;
      default:     e_alu_b = fwd_rt;
    endcase
  end

  assign e_valid      = q.valid;
  assign e_reg_we     = q.reg_we;
  assign e_pc         = q.pc;
  assign e_instr      = q.instr;
  assign e_alu_op     = q.alu_op;
  assign e_store_data = fwd_rt;
  assign e_dst        = q.dst;

endmodule
